datapath_sequencer: RTL and testbench

- Program sequencer for the single-cycle datapath.
- Generates the instruction-memory address and the RegWrite/MemWrite strobes, from an internal per-instruction write-enable table.
- Runs a contiguous instruction window [start_addr..end_addr], with wrap-around, in free-run or single-step mode.
- Provides start/done handshaking, abort and a retired-instruction count.

---
 rtl/datapath_sequencer_if.sv | 41 ++++
 rtl/datapath_sequencer.sv | 131 +++++++++++++
 tb/tb_datapath_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// Sequencer control/status bundle.
// Master drives run control and table writes; slave drives the datapath strobes.
interface datapath_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              step_mode;
  logic              step;
  logic              halt;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_reg_we;
  logic              cfg_mem_we;
  logic [ADDR_W-1:0] instruction_A;
  logic              RegWrite;
  logic              MemWrite;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  retired;

  modport master (
    output start, start_addr, end_addr,
    output step_mode, step, halt,
    output cfg_we, cfg_addr,
    output cfg_reg_we, cfg_mem_we,
    input  instruction_A, RegWrite,
    input  MemWrite, busy, done, retired
  );

  modport slave (
    input  start, start_addr, end_addr,
    input  step_mode, step, halt,
    input  cfg_we, cfg_addr,
    input  cfg_reg_we, cfg_mem_we,
    output instruction_A, RegWrite,
    output MemWrite, busy, done, retired
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Program sequencer: walks an instruction window and
// issues RegWrite/MemWrite from a per-slot enable table.
module datapath_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input logic clk,
  input logic rst,
  datapath_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_EXEC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic reg_we;
    logic mem_we;
  } ent_t;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] end_d;
  logic [CNT_W-1:0]  retired;
  logic [CNT_W-1:0]  ret_d;
  ent_t              tbl [DEPTH];

  logic              exec;
  logic              cfg_ok;
  logic              at_end;
  logic [ADDR_W-1:0] pc_nxt;
  logic [CNT_W-1:0]  ret_inc;

  assign exec   = (state == S_RUN) ||
                  (state == S_EXEC);
  assign cfg_ok = (state == S_IDLE) ||
                  (state == S_DONE);
  assign at_end = (pc == end_q);
  assign pc_nxt = pc + ADDR_W'(1);

  // Saturate so a full window never wraps the count.
  always_comb begin
    ret_inc = retired;
    if (retired != CNT_W'(DEPTH))
      ret_inc = retired + CNT_W'(1);
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    end_d   = end_q;
    ret_d   = retired;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          end_d   = bus.end_addr;
          ret_d   = '0;
          state_d = bus.step_mode ? S_WAIT
                                  : S_RUN;
        end
      end
      S_RUN: begin
        ret_d = ret_inc;
        if (bus.halt)
          state_d = S_IDLE;
        else if (at_end)
          state_d = S_DONE;
        else
          pc_d = pc_nxt;
      end
      S_WAIT: begin
        if (bus.halt)
          state_d = S_IDLE;
        else if (bus.step)
          state_d = S_EXEC;
      end
      S_EXEC: begin
        ret_d = ret_inc;
        if (bus.halt) begin
          state_d = S_IDLE;
        end else if (at_end) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_nxt;
          state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      end_q   <= '0;
      retired <= '0;
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      end_q   <= end_d;
      retired <= ret_d;
      if (bus.cfg_we && cfg_ok)
        tbl[bus.cfg_addr] <= '{
          reg_we: bus.cfg_reg_we,
          mem_we: bus.cfg_mem_we
        };
    end
  end

  assign bus.instruction_A = pc;
  assign bus.RegWrite = exec & tbl[pc].reg_we;
  assign bus.MemWrite = exec & tbl[pc].mem_we;
  assign bus.busy     = exec ||
                        (state == S_WAIT);
  assign bus.done     = (state == S_DONE);
  assign bus.retired  = retired;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with an
// address-queue reference model checked every cycle.
module tb_datapath_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_sequencer_if #(.ADDR_W(3), .CNT_W(4)) bus ();

  datapath_sequencer #(
    .ADDR_W(3), .DEPTH(8), .CNT_W(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model: a run is the list of addresses still to execute.
  bit m_act, m_step, m_exec, m_done;
  int m_pc, m_ret;
  int q[$];
  bit m_rw[8];
  bit m_mw[8];

  function automatic bit m_ex();
    return m_act && (!m_step || m_exec);
  endfunction

  function automatic void m_reset();
    m_act = 0; m_step = 0; m_exec = 0; m_done = 0;
    m_pc = 0; m_ret = 0;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      m_rw[i] = 0;
      m_mw[i] = 0;
    end
  endfunction

  task automatic m_edge();
    bit ex;
    int a;
    ex = m_ex();
    if (rst) begin
      m_reset();
    end else if (!m_act) begin
      if (bus.cfg_we) begin
        m_rw[bus.cfg_addr] = bus.cfg_reg_we;
        m_mw[bus.cfg_addr] = bus.cfg_mem_we;
      end
      if (m_done) begin
        m_done = 0;
      end else if (bus.start) begin
        q.delete();
        a = int'(bus.start_addr);
        forever begin
          q.push_back(a);
          if (a == int'(bus.end_addr)) break;
          a = (a + 1) % 8;
        end
        m_pc = q[0];
        m_ret = 0;
        m_act = 1;
        m_step = bus.step_mode;
        m_exec = 0;
      end
    end else begin
      if (ex) begin
        m_ret++;
        void'(q.pop_front());
      end
      if (bus.halt) begin
        m_act = 0;
      end else if (ex) begin
        if (q.size() == 0) begin
          m_act = 0;
          m_done = 1;
        end else begin
          m_pc = q[0];
          m_exec = 0;
        end
      end else if (bus.step) begin
        m_exec = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit e_rw, e_mw;
      e_rw = m_ex() && m_rw[m_pc];
      e_mw = m_ex() && m_mw[m_pc];
      n_run++;
      if (bus.instruction_A !== 3'(m_pc) ||
          bus.RegWrite !== e_rw ||
          bus.MemWrite !== e_mw ||
          bus.busy !== m_act ||
          bus.done !== m_done ||
          bus.retired !== 4'(m_ret)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got A=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d exp A=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d",
          $time, bus.instruction_A, bus.RegWrite,
          bus.MemWrite, bus.busy, bus.done, bus.retired,
          m_pc, e_rw, e_mw, m_act, m_done, m_ret);
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
        nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic cfg(int idx, bit r, bit m);
    bus.cfg_we = 1;
    bus.cfg_addr = 3'(idx);
    bus.cfg_reg_we = r;
    bus.cfg_mem_we = m;
    tick();
    bus.cfg_we = 0;
  endtask

  task automatic go(int s, int e, bit sm);
    bus.start = 1;
    bus.start_addr = 3'(s);
    bus.end_addr = 3'(e);
    bus.step_mode = sm;
    tick();
    bus.start = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 20) begin
      tick();
      k++;
    end
    chk("done_seen", int'(bus.done), 1);
    tick();
  endtask

  int rw1[4] = '{1, 0, 1, 0};
  int mw1[4] = '{0, 1, 1, 0};
  int seq2[4] = '{6, 7, 0, 1};

  initial begin
    int cnt;
    rst = 1;
    bus.start = 0; bus.start_addr = 0;
    bus.end_addr = 0; bus.step_mode = 0;
    bus.step = 0; bus.halt = 0;
    bus.cfg_we = 0; bus.cfg_addr = 0;
    bus.cfg_reg_we = 0; bus.cfg_mem_we = 0;
    m_reset();
    tick();
    tick();
    rst = 0;
    chk_on = 1;
    chk("rst_A", int'(bus.instruction_A), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ret", int'(bus.retired), 0);

    cfg(0, 1, 0);
    cfg(1, 0, 1);
    cfg(2, 1, 1);
    cfg(3, 0, 0);
    go(0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_A", int'(bus.instruction_A), i);
      chk("t1_rw", int'(bus.RegWrite), rw1[i]);
      chk("t1_mw", int'(bus.MemWrite), mw1[i]);
      tick();
    end
    chk("t1_done", int'(bus.done), 1);
    chk("t1_ret", int'(bus.retired), 4);
    tick();
    chk("t1_idle", int'(bus.busy), 0);
    chk("t1_rw0", int'(bus.RegWrite), 0);

    go(6, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_A", int'(bus.instruction_A), seq2[i]);
      tick();
    end
    chk("t2_ret", int'(bus.retired), 4);
    tick();
    go(5, 4, 0);
    chk("t2_A0", int'(bus.instruction_A), 5);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("t2_cycles", cnt, 8);
    chk("t2_full_ret", int'(bus.retired), 8);
    tick();

    cfg(3, 0, 1);
    go(2, 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait_busy", int'(bus.busy), 1);
      chk("t3_wait_rw", int'(bus.RegWrite), 0);
      tick();
    end
    bus.step = 1;
    tick();
    bus.step = 0;
    chk("t3_ex1_A", int'(bus.instruction_A), 2);
    chk("t3_ex1_mw", int'(bus.MemWrite), 1);
    tick();
    chk("t3_w2_A", int'(bus.instruction_A), 3);
    chk("t3_w2_mw", int'(bus.MemWrite), 0);
    tick();
    tick();
    bus.step = 1;
    tick();
    bus.step = 0;
    chk("t3_ex2_mw", int'(bus.MemWrite), 1);
    chk("t3_ex2_ret", int'(bus.retired), 1);
    tick();
    chk("t3_done", int'(bus.done), 1);
    chk("t3_ret", int'(bus.retired), 2);
    tick();

    go(0, 7, 0);
    tick();
    tick();
    chk("t4_A", int'(bus.instruction_A), 2);
    chk("t4_rw", int'(bus.RegWrite), 1);
    bus.halt = 1;
    tick();
    bus.halt = 0;
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_done", int'(bus.done), 0);
    chk("t4_ret", int'(bus.retired), 3);
    chk("t4_pc", int'(bus.instruction_A), 2);
    tick();
    chk("t4_nodone", int'(bus.done), 0);

    go(0, 3, 0);
    bus.cfg_we = 1; bus.cfg_addr = 1;
    bus.cfg_reg_we = 1; bus.cfg_mem_we = 0;
    bus.start = 1; bus.start_addr = 5;
    tick();
    bus.cfg_we = 0;
    bus.start = 0;
    chk("t5_A", int'(bus.instruction_A), 1);
    chk("t5_rw", int'(bus.RegWrite), 0);
    chk("t5_mw", int'(bus.MemWrite), 1);
    wait_done();
    bus.halt = 1;
    go(1, 1, 0);
    bus.halt = 0;
    chk("t5_rb_busy", int'(bus.busy), 1);
    chk("t5_rb_rw", int'(bus.RegWrite), 0);
    chk("t5_rb_mw", int'(bus.MemWrite), 1);
    tick();
    chk("t5_rb_ret", int'(bus.retired), 1);
    tick();

    go(0, 7, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_A", int'(bus.instruction_A), 4);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_A0", int'(bus.instruction_A), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_ret", int'(bus.retired), 0);
    chk("t6_rw", int'(bus.RegWrite), 0);
    go(0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_clr_rw", int'(bus.RegWrite), 0);
      chk("t6_clr_mw", int'(bus.MemWrite), 0);
      tick();
    end
    chk("t6_done", int'(bus.done), 1);
    tick();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed",
      n_run, n_fail);
    $finish;
  end

endmodule
